// File: rtl/ones_run_transmitter.sv
// Serial transmitter that sends a programmable number of frames, each a run of
// 1s followed by a single 0, with abort support and Moore-style registered outputs.
module ones_run_transmitter #(
  parameter int LEN_W = 4,
  parameter int FRM_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic [FRM_W-1:0] frames,
  input  logic             abort,
  output logic             x_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ONES, ZERO, ABORT} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [FRM_W:0]   FRM_ONE  = (FRM_W+1)'(1);
  localparam logic [FRM_W:0]   FRM_TWO  = (FRM_W+1)'(2);
  localparam logic [FRM_W:0]   FRM_FULL = {1'b1, {FRM_W{1'b0}}};

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt_q;
  logic [FRM_W:0]   frm_cnt_q;
  logic             x_out_q;
  logic             busy_q;
  logic             done_q;
  logic [FRM_W:0]   frm_start_d;

  // A frame count of zero stands for the full 2^FRM_W frames.
  assign frm_start_d = (frames == '0) ? FRM_FULL : {1'b0, frames};

  // Outputs are registered alongside the state so each one reflects the state
  // being entered; terminal tests use counter values before decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      bit_cnt_q <= '0;
      frm_cnt_q <= '0;
      x_out_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          x_out_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            len_q     <= run_len;
            frm_cnt_q <= frm_start_d;
            bit_cnt_q <= run_len;
            busy_q    <= 1'b1;
            if (run_len != '0) begin
              state_q <= ONES;
              x_out_q <= 1'b1;
            end else begin
              state_q <= ZERO;
              done_q  <= (frm_start_d == FRM_ONE);
            end
          end
        end

        ONES: begin
          if (abort) begin
            state_q <= ABORT;
            x_out_q <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q - LEN_ONE;
            if (bit_cnt_q == LEN_ONE) begin
              state_q <= ZERO;
              x_out_q <= 1'b0;
              done_q  <= (frm_cnt_q == FRM_ONE);
            end
          end
        end

        ZERO: begin
          if (abort) begin
            state_q <= ABORT;
            x_out_q <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            frm_cnt_q <= frm_cnt_q - FRM_ONE;
            if (frm_cnt_q == FRM_ONE) begin
              state_q <= IDLE;
              x_out_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b0;
            end else if (len_q != '0) begin
              state_q   <= ONES;
              bit_cnt_q <= len_q;
              x_out_q   <= 1'b1;
              done_q    <= 1'b0;
            end else begin
              // Zero-length frames: stay in ZERO, one cycle per frame.
              done_q <= (frm_cnt_q == FRM_TWO);
            end
          end
        end

        ABORT: begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
          frm_cnt_q <= '0;
          x_out_q   <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          x_out_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out = x_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ones_run_transmitter.sv
// Directed bench for ones_run_transmitter: expected {x_out,busy,done} triples are
// queued when a transmission is launched and popped one per cycle.
module tb_ones_run_transmitter;

  localparam int LEN_W = 4;
  localparam int FRM_W = 3;

  logic             clock;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] runLen;
  logic [FRM_W-1:0] frames;
  logic             abort;
  logic             xOut;
  logic             busy;
  logic             done;

  logic [2:0] scoreboard[$];
  int checks;
  int errors;

  ones_run_transmitter #(.LEN_W(LEN_W), .FRM_W(FRM_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .run_len(runLen),
    .frames (frames),
    .abort  (abort),
    .x_out  (xOut),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic s, input logic a, input int len, input int frm);
    start  = s;
    abort  = a;
    runLen = len[LEN_W-1:0];
    frames = frm[FRM_W-1:0];
  endtask

  task automatic checkOutput(input string tag);
    logic [2:0] observed;
    logic [2:0] expected;
    observed = {xOut, busy, done};
    checks++;
    if (scoreboard.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s: observed x/busy/done=%b, scoreboard empty (expected entry)", tag, observed);
    end else begin
      expected = scoreboard.pop_front();
      assert (observed === expected) else begin
        errors++;
        $error("[TB] FAIL %s: observed x/busy/done=%b expected=%b", tag, observed, expected);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  // Reference stream: each frame is len 1s then one 0; done only on the last 0.
  task automatic pushRun(input int len, input int frm);
    int f;
    f = (frm == 0) ? (1 << FRM_W) : frm;
    for (int fi = 0; fi < f; fi++) begin
      for (int b = 0; b < len; b++) scoreboard.push_back(3'b110);
      scoreboard.push_back((fi == f - 1) ? 3'b011 : 3'b010);
    end
  endtask

  task automatic runPlain(input int len, input int frm, input string tag);
    applyStimulus(1'b1, 1'b0, len, frm);
    pushRun(len, frm);
    scoreboard.push_back(3'b000);
    tick(tag);
    applyStimulus(1'b0, 1'b0, 9, 5);
    while (scoreboard.size() > 0) tick(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0);
    #12;
    scoreboard.push_back(3'b000);
    checkOutput("reset_state");
    reset = 1'b0;
    scoreboard.push_back(3'b000);
    tick("idle_after_reset");

    runPlain(3, 1, "len3_frm1");
    runPlain(0, 2, "len0_frm2");
    runPlain(15, 0, "len15_frm8");

    // Re-pulsed start mid-run is ignored; start in the next IDLE cycle is taken.
    applyStimulus(1'b1, 1'b0, 2, 3);
    pushRun(2, 3);
    scoreboard.push_back(3'b000);
    pushRun(1, 1);
    scoreboard.push_back(3'b000);
    tick("restart_ignored");
    applyStimulus(1'b0, 1'b0, 2, 3);
    tick("restart_ignored");
    tick("restart_ignored");
    applyStimulus(1'b1, 1'b0, 7, 1);
    tick("restart_ignored");
    applyStimulus(1'b0, 1'b0, 7, 1);
    repeat (5) tick("restart_ignored");
    tick("gap_idle");
    applyStimulus(1'b1, 1'b0, 1, 1);
    tick("back_to_back");
    applyStimulus(1'b0, 1'b0, 0, 0);
    tick("back_to_back");
    tick("back_to_back");

    // Abort on the third ONES cycle.
    applyStimulus(1'b1, 1'b0, 5, 1);
    repeat (3) scoreboard.push_back(3'b110);
    scoreboard.push_back(3'b010);
    scoreboard.push_back(3'b000);
    scoreboard.push_back(3'b000);
    tick("abort_ones");
    applyStimulus(1'b0, 1'b0, 5, 1);
    tick("abort_ones");
    tick("abort_ones");
    applyStimulus(1'b0, 1'b1, 5, 1);
    tick("abort_state");
    applyStimulus(1'b0, 1'b0, 5, 1);
    tick("abort_idle");
    tick("abort_no_done");

    // Abort alone in IDLE does nothing; start with abort in IDLE starts anyway.
    applyStimulus(1'b0, 1'b1, 4, 2);
    scoreboard.push_back(3'b000);
    tick("abort_in_idle");
    applyStimulus(1'b1, 1'b1, 1, 1);
    pushRun(1, 1);
    scoreboard.push_back(3'b000);
    tick("start_beats_abort");
    applyStimulus(1'b0, 1'b0, 0, 0);
    while (scoreboard.size() > 0) tick("start_beats_abort");

    // Reset between edges during ONES clears outputs before the next edge.
    applyStimulus(1'b1, 1'b0, 5, 1);
    scoreboard.push_back(3'b110);
    scoreboard.push_back(3'b110);
    tick("pre_reset_ones");
    applyStimulus(1'b0, 1'b0, 5, 1);
    tick("pre_reset_ones");
    #2 reset = 1'b1;
    #1;
    scoreboard.push_back(3'b000);
    checkOutput("async_reset");
    #2 reset = 1'b0;
    scoreboard.push_back(3'b000);
    tick("post_reset_idle");
    runPlain(1, 1, "post_reset_len1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ones_run_transmitter.md
ONES_RUN_TRANSMITTER -- requirements
Module: ones_run_transmitter

Interface
REQ-001 The block SHALL have the parameter LEN_W, default 4, setting the width of the run-length field.
REQ-002 The block SHALL have the parameter FRM_W, default 3, setting the width of the frame-count field.
REQ-003 The block SHALL have the port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have the port start, input, 1 bit: request to begin a transmission; sampled only in IDLE.
REQ-006 The block SHALL have the port run_len, input, LEN_W bits: the number of 1s per frame; captured on an accepted start.
REQ-007 The block SHALL have the port frames, input, FRM_W bits: the number of frames to send; 0 means 2^FRM_W; captured on an accepted start.
REQ-008 The block SHALL have the port abort, input, 1 bit: a synchronous request to terminate the transmission in progress.
REQ-009 The block SHALL have the port x_out, output, 1 bit: the serial bit stream.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while a transmission is in progress.
REQ-011 The block SHALL have the port done, output, 1 bit: a one-cycle pulse marking normal completion.

Function
REQ-012 The block SHALL implement a Moore state machine with states IDLE, ONES, ZERO and ABORT.
REQ-013 x_out, busy and done SHALL be decoded from registered state only, with no combinational path from any input.
REQ-014 IDLE outputs SHALL be x_out=0, busy=0, done=0.
REQ-015 In IDLE with start=1 at an edge, the block SHALL capture run_len into len_r and frames into frm_r (0 mapped to 2^FRM_W), load the bit counter with len_r, and move to ONES if len_r>0, otherwise to ZERO.
REQ-016 ONES SHALL drive x_out=1 and busy=1, and SHALL decrement the bit counter each cycle; after exactly len_r cycles it SHALL move to ZERO.
REQ-017 ZERO SHALL drive x_out=0 and busy=1 for exactly one cycle, and SHALL decrement the frame counter.
REQ-018 On leaving ZERO, if frames remain the block SHALL reload the bit counter and return to ONES (or stay in ZERO when len_r=0); otherwise it SHALL go to IDLE.
REQ-019 done SHALL be 1 exactly during the final ZERO cycle of the last frame and 0 in every other cycle.
REQ-020 The latency from an accepted start edge to the first frame bit on x_out SHALL be zero cycles: the bit is valid immediately after that edge.
REQ-021 A normal transmission SHALL keep busy high for exactly F*(L+1) consecutive cycles, where F=frm_r and L=len_r.
REQ-022 start SHALL be ignored while busy=1, and inputs captured at start SHALL not change mid-transmission.
REQ-023 The block SHALL accept a start asserted in the first IDLE cycle after completion, so back-to-back transmissions leave one idle cycle between them.
REQ-024 abort=1 in ONES or ZERO SHALL move the block to ABORT.
REQ-025 ABORT SHALL drive x_out=0, busy=1, done=0 for exactly one cycle and then go to IDLE.
REQ-026 abort SHALL take priority over all other transitions, including the final ZERO of the last frame: that transmission SHALL produce no done pulse.
REQ-027 abort in IDLE SHALL be ignored, and when start and abort are both high in IDLE, start SHALL win.
REQ-028 Every frame SHALL end with exactly one 0, so no two frames merge into a longer run.
REQ-029 The bit and frame counters SHALL never wrap: their terminal tests SHALL be done on the value before decrement.

Reset
REQ-030 reset=1 SHALL, asynchronously, force state to IDLE, x_out=0, busy=0, done=0, and clear all counters and captured registers.
REQ-031 Reset asserted mid-transmission SHALL drop the stream immediately without a done pulse, and operation SHALL resume on the first edge after deassertion.

Verification
REQ-032 The bench SHALL cover: run_len=3, frames=1, start pulse -> x_out = 1,1,1,0 then 0; busy high 4 cycles; done high on cycle 4 only.
REQ-033 The bench SHALL cover: run_len=0, frames=2 -> x_out = 0,0 with busy high 2 cycles; done on cycle 2.
REQ-034 The bench SHALL cover: run_len=15, frames=0 -> 8 frames of fifteen 1s plus one 0; busy high 128 cycles; one done pulse.
REQ-035 The bench SHALL cover: run_len=2, frames=3, with start re-pulsed on cycle 3 -> x_out = 110110110; second start ignored; a start in the following IDLE cycle is accepted.
REQ-036 The bench SHALL cover: run_len=5, frames=1, with abort on the 3rd ONES cycle -> x_out = 1,1,1,0 (ABORT), then IDLE; busy low on cycle 5; no done pulse.
REQ-037 The bench SHALL cover: reset asserted between clock edges during ONES -> x_out and busy go to 0 before the next edge; after deassertion, a start with run_len=1, frames=1 gives x_out = 1,0.
